// File: rtl/spi_pkg.sv
// Shared definitions for the SPI peripheral.
//   spi_state_e            : peripheral FSM states
//   SPI_MODE/CPOL/CPHA     : SPI mode implemented by the peripheral (mode 1)
//   SPI_DEFAULT_DATA_WIDTH : default bits per frame byte
package spi_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,  // CS deasserted
        StSelected = 2'd1,  // CS asserted, waiting for the first rising SCLK of a byte
        StShift    = 2'd2   // mid-byte
    } spi_state_e;

    localparam logic [1:0]  SPI_MODE = 2'd1;
    localparam logic        SPI_CPOL = SPI_MODE[1];
    localparam logic        SPI_CPHA = SPI_MODE[0];

    localparam int unsigned SPI_DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : asynchronous input
//   level      : synchronized level
//   rise, fall : one-cycle pulses on synchronized 0->1 / 1->0 transitions
module spi_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stages;
    logic [SYNC_STAGES:0]   chain;
    logic                   prev;

    assign chain = {stages, din};

    // Edge history resets to the same value as the chain, so releasing reset
    // never manufactures an edge on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= {SYNC_STAGES{RESET_VALUE}};
            prev   <= RESET_VALUE;
        end else begin
            stages <= chain[SYNC_STAGES-1:0];
            prev   <= stages[SYNC_STAGES-1];
        end
    end

    assign level = stages[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-1 peripheral with a one-entry TX holding register.
//   clock_i, reset_ni       : system clock, asynchronous active-low reset
//   SCLK_i, CS_ni, MOSI_i   : asynchronous SPI pins from the controller
//   MISO_o, MISO_oe_o       : serial data out and its output enable
//   tx_buffer_i/valid/ready : byte handshake into the holding register
//   rx_buffer_o, rx_valid_o : last received byte and its update pulse
//   underrun_o, abort_o     : byte started with empty holding reg / CS lost mid-byte
//   busy_o                  : FSM not idle
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = SPI_DEFAULT_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic                  SCLK_i,
    input  logic                  CS_ni,
    input  logic                  MOSI_i,
    output logic                  MISO_o,
    output logic                  MISO_oe_o,
    input  logic [DATA_WIDTH-1:0] tx_buffer_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_buffer_o,
    output logic                  rx_valid_o,
    output logic                  underrun_o,
    output logic                  abort_o,
    output logic                  busy_o
);

    localparam int unsigned     CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(SPI_CPOL)) u_sync_sclk (
        .clk   (clock_i),
        .rst_n (reset_ni),
        .din   (SCLK_i),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // CS resets to "deasserted" so a reset released mid-frame starts from IDLE.
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs (
        .clk   (clock_i),
        .rst_n (reset_ni),
        .din   (CS_ni),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
        .clk   (clock_i),
        .rst_n (reset_ni),
        .din   (MOSI_i),
        .level (mosi_level),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_level, cs_level, mosi_rise, mosi_fall};

    // With CPHA=1 data launches on the leading edge and is captured on the trailing one.
    logic drive_edge, sample_edge;
    assign drive_edge  = SPI_CPHA ? sclk_rise : sclk_fall;
    assign sample_edge = SPI_CPHA ? sclk_fall : sclk_rise;

    spi_state_e            state, state_next;
    logic [DATA_WIDTH-1:0] tx_shift, rx_shift, rx_next, hold;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  hold_full, hold_full_next, hold_write;
    logic                  rx_valid_q, underrun_q, abort_q;
    logic                  load, tx_step, rx_step, byte_done, abort_evt;

    assign rx_next    = {rx_shift[DATA_WIDTH-2:0], mosi_level};
    assign hold_write = tx_valid_i & ~hold_full;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        tx_step    = 1'b0;
        rx_step    = 1'b0;
        byte_done  = 1'b0;
        abort_evt  = 1'b0;
        if (cs_rise) begin
            // Deselect wins over any SCLK activity in the same cycle.
            state_next = StIdle;
            abort_evt  = (state == StShift);
        end else begin
            unique case (state)
                StIdle: begin
                    if (cs_fall) state_next = StSelected;
                end
                StSelected: begin
                    if (drive_edge) begin
                        state_next = StShift;
                        load       = 1'b1;
                    end
                end
                StShift: begin
                    tx_step = drive_edge;
                    if (sample_edge) begin
                        rx_step = 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            byte_done  = 1'b1;
                            state_next = StSelected;
                        end
                    end
                end
                default: state_next = StIdle;
            endcase
        end
    end

    // A load empties the register; a write in the same cycle refills it.
    always_comb begin
        hold_full_next = hold_full;
        if (load)       hold_full_next = 1'b0;
        if (hold_write) hold_full_next = 1'b1;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hold        <= '0;
            hold_full   <= 1'b0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            rx_buffer_o <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            hold_full  <= hold_full_next;
            rx_valid_q <= byte_done;
            underrun_q <= load & ~hold_full;
            abort_q    <= abort_evt;

            if (hold_write) hold <= tx_buffer_i;

            if (load) begin
                tx_shift <= hold_full ? hold : '0;
            end else if (tx_step) begin
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end

            if (cs_rise) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (rx_step) begin
                rx_shift <= rx_next;
                if (byte_done) begin
                    bit_cnt     <= '0;
                    rx_buffer_o <= rx_next;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign busy_o     = (state != StIdle);
    assign MISO_oe_o  = (state != StIdle);
    assign MISO_o     = MISO_oe_o & tx_shift[DATA_WIDTH-1];
    assign tx_ready_o = ~hold_full;
    assign rx_valid_o = rx_valid_q;
    assign underrun_o = underrun_q;
    assign abort_o    = abort_q;

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set bits per frame byte.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth on SCLK_i, MOSI_i and CS_ni.
REQ-003 clock_i  input  1  system clock; all logic SHALL be synchronous to its rising edge.
REQ-004 reset_ni  input  1  asynchronous, active-low reset.
REQ-005 SCLK_i  input  1  controller serial clock, asynchronous to clock_i, CPOL=0.
REQ-006 CS_ni  input  1  controller chip select, active low, asynchronous.
REQ-007 MOSI_i  input  1  controller-to-peripheral serial data, MSB first.
REQ-008 MISO_o  output  1  peripheral-to-controller serial data, MSB first.
REQ-009 MISO_oe_o  output  1  MISO output enable, high only while selected.
REQ-010 tx_buffer_i  input  DATA_WIDTH  next byte to transmit.
REQ-011 tx_valid_i  input  1  tx_buffer_i valid; a transfer occurs when tx_valid_i and tx_ready_o are both high.
REQ-012 tx_ready_o  output  1  high while the one-entry TX holding register is empty.
REQ-013 rx_buffer_o  output  DATA_WIDTH  last complete received byte.
REQ-014 rx_valid_o  output  1  one-cycle pulse when rx_buffer_o updates.
REQ-015 underrun_o  output  1  one-cycle pulse when a byte starts with the holding register empty.
REQ-016 abort_o  output  1  one-cycle pulse when CS_ni deasserts mid-byte.
REQ-017 busy_o  output  1  high in any state other than IDLE.

Function
REQ-018 The block SHALL implement SPI mode 1 (CPOL=0, CPHA=1): drive MISO on SCLK rising edges and sample MOSI on SCLK falling edges.
REQ-019 SCLK and CS edges SHALL be detected from the synchronized samples; a detected edge SHALL act exactly 1 clock_i cycle after detection (pin-to-action latency SYNC_STAGES+1 cycles).
REQ-020 Correct operation SHALL require each SCLK half-period and the CS-to-first-edge setup to be at least SYNC_STAGES+2 clock_i cycles.
REQ-021 The FSM SHALL have three states: IDLE (CS high), SELECTED (CS low, waiting for the first rising edge of a byte), and SHIFT (mid-byte).
REQ-022 IDLE->SELECTED SHALL occur on a synchronized CS falling edge; MISO_oe_o SHALL go high on the same cycle.
REQ-023 SELECTED->SHIFT SHALL occur on a rising SCLK edge, which SHALL perform the load below.
REQ-024 Load: if the holding register is full, its value SHALL move to the TX shift register and the register SHALL empty; otherwise the shift register SHALL load all-zeros and underrun_o SHALL pulse.
REQ-025 On the load edge MISO_o SHALL present bit DATA_WIDTH-1; each subsequent rising edge within the byte SHALL present the next lower bit.
REQ-026 Each falling edge SHALL shift MOSI into the RX shift register and increment the bit counter.
REQ-027 On the DATA_WIDTH-th falling edge, rx_buffer_o SHALL update, rx_valid_o SHALL pulse on the next cycle, the counter SHALL clear, and the FSM SHALL return to SELECTED, so multi-byte frames stream without CS toggling.
REQ-028 A synchronized CS rising edge SHALL force IDLE from any state and drive MISO_oe_o low; in SHIFT it SHALL discard the partial byte, suppress rx_valid_o, and pulse abort_o.
REQ-029 The holding register SHALL accept writes in any state; a write and a load in the same cycle SHALL leave the register full with the new byte.
REQ-030 tx_ready_o SHALL depend only on the registered full flag, with no combinational path from tx_valid_i.
REQ-031 MISO_o SHALL be 0 whenever MISO_oe_o is low.

Reset
REQ-032 While reset_ni is low: FSM in IDLE, shift registers, bit counter and rx_buffer_o zero, holding register empty (tx_ready_o=1), and MISO_o, MISO_oe_o, rx_valid_o, underrun_o, abort_o and busy_o all 0.
REQ-033 Synchronizer stages SHALL reset so that CS reads deasserted and SCLK reads low, so that reset release mid-frame does not produce a spurious edge.

Structure
REQ-034 Package spi_pkg SHALL hold the FSM state enum, the SPI mode constants and the default DATA_WIDTH.
REQ-035 Sub-module spi_sync SHALL be the single synchronizer with rise/fall edge detection, instantiated once each for SCLK_i, CS_ni and MOSI_i.

Verification
REQ-036 Hold 0x69 loaded; CS low, controller sends 0x87 in mode 1 -> MISO bits 0,1,1,0,1,0,0,1; rx_buffer_o=0x87 with one rx_valid_o pulse.
REQ-037 Three-byte frame sending 0xAA,0xBB,0xCC, with the TX bytes 0x11,0x22,0x33 each written after tx_ready_o -> three rx_valid_o pulses and MISO carries 0x11,0x22,0x33.
REQ-038 Holding register empty at byte start -> MISO sends 0x00, exactly one underrun_o pulse, and the received byte is still correct.
REQ-039 CS_ni raised after 4 SCLK falling edges -> abort_o pulses, no rx_valid_o, FSM in IDLE, MISO_oe_o=0; the next frame receives 0x5A correctly.
REQ-040 reset_ni asserted mid-byte -> all outputs at reset values within the same cycle, tx_ready_o=1, and no spurious edge after release.
